// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: tag allocation, dual-CDB result capture,
// operand lookup with same-cycle CDB bypass, and in-order retirement.
module reorder_buffer #(
   parameter int unsigned DEPTH   = 16,
   parameter logic [5:0]  INVALID = 6'd16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        alloc_valid,
   input  logic [4:0]  alloc_dest,
   output logic        alloc_ready,
   output logic [5:0]  alloc_rob,
   input  logic        cdb_valid,
   input  logic [5:0]  cdb_rob,
   input  logic [31:0] cdb_data,
   input  logic        cdb_valid2,
   input  logic [5:0]  cdb_rob2,
   input  logic [31:0] cdb_data2,
   input  logic [5:0]  index_a,
   input  logic [5:0]  index_b,
   output logic        ready_a,
   output logic        ready_b,
   output logic [31:0] value_a,
   output logic [31:0] value_b,
   output logic        commit_valid,
   output logic [4:0]  commit_dest,
   output logic [31:0] commit_data,
   output logic [5:0]  commit_rob,
   output logic [4:0]  count
);

   localparam int unsigned PTR_W  = 4;
   localparam int unsigned TAG_W  = 6;
   localparam int unsigned DEST_W = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 5;

   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [DEPTH-1:0]  done_q, done_d;
   logic [DEST_W-1:0] dest_q [DEPTH];
   logic [DEST_W-1:0] dest_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              commit_valid_q, commit_valid_d;
   logic [DEST_W-1:0] commit_dest_q, commit_dest_d;
   logic [DATA_W-1:0] commit_data_q, commit_data_d;
   logic [TAG_W-1:0]  commit_rob_q, commit_rob_d;

   logic              alloc_fire;
   logic              commit_fire;
   logic              hit1, hit2;
   logic [PTR_W-1:0]  e1, e2;

   // Allocation view depends only on registered count and tail
   assign alloc_ready = (count_q < CNT_W'(DEPTH));
   assign alloc_rob   = alloc_ready ? TAG_W'(tail_q) : INVALID;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign commit_fire = busy_q[head_q] && done_q[head_q];

   assign e1   = cdb_rob[PTR_W-1:0];
   assign e2   = cdb_rob2[PTR_W-1:0];
   assign hit1 = cdb_valid  && (cdb_rob  < TAG_W'(DEPTH)) && busy_q[e1] && !done_q[e1];
   assign hit2 = cdb_valid2 && (cdb_rob2 < TAG_W'(DEPTH)) && busy_q[e2] && !done_q[e2];

   // Stored result first, then bypass from CDB port 1, then port 2
   function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] idx);
      logic [PTR_W-1:0] e;
      logic [DATA_W:0]  res;
      e   = idx[PTR_W-1:0];
      res = '0;
      if ((idx < TAG_W'(DEPTH)) && busy_q[e]) begin
         if (done_q[e])
            res = {1'b1, data_q[e]};
         else if (cdb_valid && (cdb_rob == idx))
            res = {1'b1, cdb_data};
         else if (cdb_valid2 && (cdb_rob2 == idx))
            res = {1'b1, cdb_data2};
      end
      return res;
   endfunction

   assign {ready_a, value_a} = lookup(index_a);
   assign {ready_b, value_b} = lookup(index_b);

   always_comb begin
      busy_d         = busy_q;
      done_d         = done_q;
      dest_d         = dest_q;
      data_d         = data_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_valid_d = 1'b0;
      commit_dest_d  = commit_dest_q;
      commit_data_d  = commit_data_q;
      commit_rob_d   = commit_rob_q;

      if (flush) begin
         busy_d  = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (commit_fire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            commit_valid_d = 1'b1;
            commit_dest_d  = dest_q[head_q];
            commit_data_d  = data_q[head_q];
            commit_rob_d   = TAG_W'(head_q);
            head_d         = head_q + PTR_W'(1);
         end
         // Port 2 written first so port 1 overrides on a shared target
         if (hit2) begin
            done_d[e2] = 1'b1;
            data_d[e2] = cdb_data2;
         end
         if (hit1) begin
            done_d[e1] = 1'b1;
            data_d[e1] = cdb_data;
         end
         if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            dest_d[tail_q] = alloc_dest;
            tail_d         = tail_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q         <= '0;
         done_q         <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_dest_q  <= '0;
         commit_data_q  <= '0;
         commit_rob_q   <= INVALID;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            dest_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         busy_q         <= busy_d;
         done_q         <= done_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_dest_q  <= commit_dest_d;
         commit_data_q  <= commit_data_d;
         commit_rob_q   <= commit_rob_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            dest_q[i] <= dest_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign commit_valid = commit_valid_q;
   assign commit_dest  = commit_dest_q;
   assign commit_data  = commit_data_q;
   assign commit_rob   = commit_rob_q;
   assign count        = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, corner-case sequences and
// randomized traffic against a queue-based program-order model.
module tb_reorder_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        alloc_valid;
   logic [4:0]  alloc_dest;
   logic        alloc_ready;
   logic [5:0]  alloc_rob;
   logic        cdb_valid, cdb_valid2;
   logic [5:0]  cdb_rob, cdb_rob2;
   logic [31:0] cdb_data, cdb_data2;
   logic [5:0]  index_a, index_b;
   logic        ready_a, ready_b;
   logic [31:0] value_a, value_b;
   logic        commit_valid;
   logic [4:0]  commit_dest;
   logic [31:0] commit_data;
   logic [5:0]  commit_rob;
   logic [4:0]  count;

   int errors = 0;
   int checks = 0;

   reorder_buffer dut (
      .clock(clock), .reset(reset), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
      .alloc_ready(alloc_ready), .alloc_rob(alloc_rob),
      .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
      .cdb_valid2(cdb_valid2), .cdb_rob2(cdb_rob2), .cdb_data2(cdb_data2),
      .index_a(index_a), .index_b(index_b),
      .ready_a(ready_a), .ready_b(ready_b),
      .value_a(value_a), .value_b(value_b),
      .commit_valid(commit_valid), .commit_dest(commit_dest),
      .commit_data(commit_data), .commit_rob(commit_rob),
      .count(count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      flush = 1'b0; alloc_valid = 1'b0; alloc_dest = '0;
      cdb_valid = 1'b0; cdb_rob = '0; cdb_data = '0;
      cdb_valid2 = 1'b0; cdb_rob2 = '0; cdb_data2 = '0;
      index_a = 6'd16; index_b = 6'd16;
   endtask

   // Leaves the bench at posedge+1 with a freshly reset DUT
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      idle_inputs();
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  dest;
      bit          done;
      logic [31:0] data;
   } ment_t;

   ment_t       mq[$];
   int          mtail;
   bit          m_cv;
   logic [4:0]  m_cdest;
   logic [31:0] m_cdata;
   logic [5:0]  m_crob;

   function automatic void model_reset();
      mq.delete();
      mtail = 0; m_cv = 0; m_cdest = '0; m_cdata = '0; m_crob = 6'd16;
   endfunction

   function automatic logic [32:0] m_look(input logic [5:0] idx);
      if (idx < 6'd16) begin
         foreach (mq[i]) begin
            if (mq[i].tag == idx[3:0]) begin
               if (mq[i].done) return {1'b1, mq[i].data};
               if (cdb_valid && cdb_rob == idx) return {1'b1, cdb_data};
               if (cdb_valid2 && cdb_rob2 == idx) return {1'b1, cdb_data2};
            end
         end
      end
      return 33'd0;
   endfunction

   function automatic void m_cdb(input logic v, input logic [5:0] rob, input logic [31:0] d);
      if (!v || rob >= 6'd16) return;
      foreach (mq[i]) begin
         if (mq[i].tag == rob[3:0] && !mq[i].done) begin
            mq[i].done = 1'b1;
            mq[i].data = d;
         end
      end
   endfunction

   function automatic void model_step();
      int sz = mq.size();
      if (flush) begin
         mq.delete();
         mtail = 0;
         m_cv  = 0;
         return;
      end
      m_cv = 0;
      if (sz > 0 && mq[0].done) begin
         m_cv    = 1;
         m_cdest = mq[0].dest;
         m_cdata = mq[0].data;
         m_crob  = 6'(mq[0].tag);
         void'(mq.pop_front());
      end
      m_cdb(cdb_valid, cdb_rob, cdb_data);
      m_cdb(cdb_valid2, cdb_rob2, cdb_data2);
      if (alloc_valid && sz < 16) begin
         mq.push_back('{tag: 4'(mtail), dest: alloc_dest, done: 1'b0, data: 32'd0});
         mtail = (mtail + 1) % 16;
      end
   endfunction

   function automatic logic [5:0] pick_tag();
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
         return 6'(mq[$urandom_range(0, mq.size() - 1)].tag);
      return 6'($urandom_range(0, 40));
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        fl, av;
      logic [4:0]  ad;
      logic        c1v;
      logic [5:0]  c1r;
      logic [31:0] c1d;
      logic        c2v;
      logic [5:0]  c2r;
      logic [31:0] c2d;
      logic [5:0]  ia, ib;
      logic        e_ar;
      logic [5:0]  e_arob;
      logic        e_ra;
      logic [31:0] e_va;
      logic        e_rb;
      logic [31:0] e_vb;
      logic [4:0]  e_cnt;
      logic        e_cv;
      logic [5:0]  e_crob;
      logic [31:0] e_cd;
   } vec_t;

   function automatic vec_t mk(input int fl, av, ad, c1v, c1r, c1d, c2v, c2r, c2d,
                               ia, ib, ar, arob, ra, va, rb, vb, cnt, cv, crob, cd);
      vec_t v;
      v.fl = 1'(fl); v.av = 1'(av); v.ad = 5'(ad);
      v.c1v = 1'(c1v); v.c1r = 6'(c1r); v.c1d = 32'(c1d);
      v.c2v = 1'(c2v); v.c2r = 6'(c2r); v.c2d = 32'(c2d);
      v.ia = 6'(ia); v.ib = 6'(ib);
      v.e_ar = 1'(ar); v.e_arob = 6'(arob);
      v.e_ra = 1'(ra); v.e_va = 32'(va); v.e_rb = 1'(rb); v.e_vb = 32'(vb);
      v.e_cnt = 5'(cnt); v.e_cv = 1'(cv); v.e_crob = 6'(crob); v.e_cd = 32'(cd);
      return v;
   endfunction

   localparam int NV = 18;
   vec_t vt[NV];

   initial begin
      logic [32:0] r;
      int bias;

      //        fl av ad  c1v c1r c1d      c2v c2r c2d      ia  ib  ar arob ra va      rb vb      cnt cv crob cd
      vt[0]  = mk(0, 1, 1,  0, 0, 0,        0, 0,  0,        0, 16,  1, 0,  0, 0,       0, 0,       1, 0, 16, 0);
      vt[1]  = mk(0, 1, 2,  0, 0, 0,        0, 0,  0,        0, 16,  1, 1,  0, 0,       0, 0,       2, 0, 16, 0);
      vt[2]  = mk(0, 1, 3,  0, 0, 0,        0, 0,  0,        0, 16,  1, 2,  0, 0,       0, 0,       3, 0, 16, 0);
      vt[3]  = mk(0, 0, 0,  1, 1, 'h55,     0, 0,  0,        1,  0,  1, 3,  1, 'h55,    0, 0,       3, 0, 16, 0);
      vt[4]  = mk(0, 0, 0,  1, 0, 'h11,     0, 0,  0,        1,  0,  1, 3,  1, 'h55,    1, 'h11,    3, 0, 16, 0);
      vt[5]  = mk(0, 0, 0,  0, 0, 0,        0, 0,  0,        0,  1,  1, 3,  1, 'h11,    1, 'h55,    2, 1,  0, 'h11);
      vt[6]  = mk(0, 0, 0,  0, 0, 0,        0, 0,  0,        0,  2,  1, 3,  0, 0,       0, 0,       1, 1,  1, 'h55);
      vt[7]  = mk(0, 0, 0,  0, 0, 0,        0, 0,  0,        2, 16,  1, 3,  0, 0,       0, 0,       1, 0,  1, 'h55);
      vt[8]  = mk(0, 1, 4,  0, 0, 0,        0, 0,  0,       16, 16,  1, 3,  0, 0,       0, 0,       2, 0,  1, 'h55);
      vt[9]  = mk(0, 1, 5,  0, 0, 0,        0, 0,  0,       16, 16,  1, 4,  0, 0,       0, 0,       3, 0,  1, 'h55);
      vt[10] = mk(0, 0, 0,  1, 4, 'hAAAA,   1, 4,  'hBBBB,   4, 16,  1, 5,  1, 'hAAAA,  0, 0,       3, 0,  1, 'h55);
      vt[11] = mk(0, 0, 0,  1, 2, 'h22,     1, 16, 'h9999,   4, 16,  1, 5,  1, 'hAAAA,  0, 0,       3, 0,  1, 'h55);
      vt[12] = mk(0, 0, 0,  1, 3, 'h33,     0, 0,  0,        2,  3,  1, 5,  1, 'h22,    1, 'h33,    2, 1,  2, 'h22);
      vt[13] = mk(0, 0, 0,  0, 0, 0,        0, 0,  0,        4, 16,  1, 5,  1, 'hAAAA,  0, 0,       1, 1,  3, 'h33);
      vt[14] = mk(0, 0, 0,  0, 0, 0,        0, 0,  0,        4, 16,  1, 5,  1, 'hAAAA,  0, 0,       0, 1,  4, 'hAAAA);
      vt[15] = mk(0, 1, 6,  0, 0, 0,        0, 0,  0,        4, 16,  1, 5,  0, 0,       0, 0,       1, 0,  4, 'hAAAA);
      vt[16] = mk(0, 0, 0,  0, 0, 0,        1, 5,  'h1234,   5, 16,  1, 6,  1, 'h1234,  0, 0,       1, 0,  4, 'hAAAA);
      vt[17] = mk(0, 0, 0,  0, 0, 0,        0, 0,  0,        5, 16,  1, 6,  1, 'h1234,  0, 0,       0, 1,  5, 'h1234);

      // Reset state
      reset = 1'b1;
      idle_inputs();
      #3;
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_rob", alloc_rob, 0);
      chk("rst_count", count, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_commit_rob", commit_rob, 16);
      chk("rst_commit_data", commit_data, 0);
      chk("rst_commit_dest", commit_dest, 0);
      chk("rst_ready_a", ready_a, 0);
      chk("rst_value_a", value_a, 0);
      do_reset();

      for (int i = 0; i < NV; i++) begin
         flush = vt[i].fl; alloc_valid = vt[i].av; alloc_dest = vt[i].ad;
         cdb_valid = vt[i].c1v; cdb_rob = vt[i].c1r; cdb_data = vt[i].c1d;
         cdb_valid2 = vt[i].c2v; cdb_rob2 = vt[i].c2r; cdb_data2 = vt[i].c2d;
         index_a = vt[i].ia; index_b = vt[i].ib;
         #1;
         chk($sformatf("vec%0d_alloc_ready", i), alloc_ready, vt[i].e_ar);
         chk($sformatf("vec%0d_alloc_rob", i), alloc_rob, vt[i].e_arob);
         chk($sformatf("vec%0d_ready_a", i), ready_a, vt[i].e_ra);
         chk($sformatf("vec%0d_value_a", i), value_a, vt[i].e_va);
         chk($sformatf("vec%0d_ready_b", i), ready_b, vt[i].e_rb);
         chk($sformatf("vec%0d_value_b", i), value_b, vt[i].e_vb);
         @(posedge clock); #1;
         chk($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
         chk($sformatf("vec%0d_commit_valid", i), commit_valid, vt[i].e_cv);
         chk($sformatf("vec%0d_commit_rob", i), commit_rob, vt[i].e_crob);
         chk($sformatf("vec%0d_commit_data", i), commit_data, vt[i].e_cd);
      end
      idle_inputs();

      // Fill to full, ignore a 17th request, then wrap the tail
      do_reset();
      for (int i = 0; i < 16; i++) begin
         alloc_valid = 1'b1; alloc_dest = 5'(i);
         #1;
         chk("fill_alloc_rob", alloc_rob, 32'(i));
         @(posedge clock); #1;
      end
      chk("full_count", count, 16);
      chk("full_alloc_ready", alloc_ready, 0);
      chk("full_alloc_rob", alloc_rob, 16);
      @(posedge clock); #1;
      chk("full_ignore_count", count, 16);
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_rob = 6'd0; cdb_data = 32'hF0;
      @(posedge clock); #1;
      cdb_valid = 1'b0;
      chk("full_no_early_commit", commit_valid, 0);
      @(posedge clock); #1;
      chk("wrap_commit_valid", commit_valid, 1);
      chk("wrap_commit_rob", commit_rob, 0);
      chk("wrap_commit_data", commit_data, 32'hF0);
      chk("wrap_commit_dest", commit_dest, 0);
      chk("wrap_count", count, 15);
      chk("wrap_alloc_rob", alloc_rob, 0);

      // Flush with done entries behind a pending head
      do_reset();
      for (int i = 0; i < 5; i++) begin
         alloc_valid = 1'b1; alloc_dest = 5'(i + 8);
         @(posedge clock); #1;
      end
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_rob = 6'd2; cdb_data = 32'h202;
      cdb_valid2 = 1'b1; cdb_rob2 = 6'd3; cdb_data2 = 32'h303;
      @(posedge clock); #1;
      cdb_rob = 6'd0; cdb_data = 32'h404; cdb_valid2 = 1'b0;
      alloc_valid = 1'b1; flush = 1'b1;
      @(posedge clock); #1;
      idle_inputs();
      chk("flush_count", count, 0);
      chk("flush_alloc_rob", alloc_rob, 0);
      chk("flush_commit_valid", commit_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         chk("flush_no_stale_commit", commit_valid, 0);
         chk("flush_count_hold", count, 0);
      end

      // Asynchronous reset between edges with 8 entries busy
      do_reset();
      for (int i = 0; i < 8; i++) begin
         alloc_valid = 1'b1; alloc_dest = 5'(i);
         @(posedge clock); #1;
      end
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_rob = 6'd3; cdb_data = 32'h77;
      @(posedge clock); #1;
      cdb_valid = 1'b1; cdb_rob = 6'd4; cdb_data = 32'h88;
      index_a = 6'd3; index_b = 6'd4;
      #1;
      chk("pre_rst_ready_a", ready_a, 1);
      chk("pre_rst_ready_b", ready_b, 1);
      chk("pre_rst_count", count, 8);
      #1 reset = 1'b1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_alloc_ready", alloc_ready, 1);
      chk("arst_alloc_rob", alloc_rob, 0);
      chk("arst_ready_a", ready_a, 0);
      chk("arst_value_a", value_a, 0);
      chk("arst_ready_b", ready_b, 0);
      chk("arst_commit_rob", commit_rob, 16);
      @(negedge clock);
      reset = 1'b0;
      idle_inputs();
      alloc_valid = 1'b1; alloc_dest = 5'd9;
      #1;
      chk("arst_restart_rob", alloc_rob, 0);
      @(posedge clock); #1;
      alloc_valid = 1'b0;
      chk("arst_restart_count", count, 1);

      // Randomized traffic against the model
      do_reset();
      model_reset();
      bias = 5;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 250 == 0) bias = int'($urandom_range(1, 9));
         flush       = ($urandom_range(0, 99) == 0);
         alloc_valid = ($urandom_range(0, 9) < bias);
         alloc_dest  = 5'($urandom);
         cdb_valid   = ($urandom_range(0, 9) >= bias - 1);
         cdb_rob     = pick_tag();
         cdb_data    = $urandom;
         cdb_valid2  = ($urandom_range(0, 9) >= bias - 1);
         cdb_rob2    = ($urandom_range(0, 3) == 0) ? cdb_rob : pick_tag();
         cdb_data2   = $urandom;
         index_a     = pick_tag();
         index_b     = pick_tag();
         #1;
         chk("rnd_alloc_ready", alloc_ready, (mq.size() < 16) ? 1 : 0);
         chk("rnd_alloc_rob", alloc_rob, (mq.size() < 16) ? 32'(mtail) : 16);
         r = m_look(index_a);
         chk("rnd_ready_a", ready_a, 32'(r[32]));
         chk("rnd_value_a", value_a, r[31:0]);
         r = m_look(index_b);
         chk("rnd_ready_b", ready_b, 32'(r[32]));
         chk("rnd_value_b", value_b, r[31:0]);
         @(posedge clock);
         model_step();
         #1;
         chk("rnd_count", count, 32'(mq.size()));
         chk("rnd_commit_valid", commit_valid, 32'(m_cv));
         chk("rnd_commit_rob", commit_rob, 32'(m_crob));
         chk("rnd_commit_dest", commit_dest, 32'(m_cdest));
         chk("rnd_commit_data", commit_data, m_cdata);
      end
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

16-entry in-order reorder buffer (ROB) at the producer/consumer end of the reservation-station protocol. It allocates the ROB tags that dispatch hands to the add/load/branch reservation stations, captures results from both CDB ports, and answers operand-readiness queries on an index/ready/value lookup. It retires completed entries strictly in program order toward the register file. It sits between dispatch, the two CDB broadcasters and register writeback.

## Interface
Parameters:
- DEPTH, 16, number of entries; tags 0..15 are valid.
- INVALID, 6'd16, "no tag" encoding, shared with the reservation stations.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous clear (mispredict); highest priority after reset.
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_dest  in  5  architectural destination register of the instruction.
- alloc_ready  out  1  an entry is free (count < DEPTH).
- alloc_rob  out  6  tag that will be assigned (tail); INVALID when full.
- cdb_valid / cdb_rob / cdb_data  in  1/6/32  CDB port 1.
- cdb_valid2 / cdb_rob2 / cdb_data2  in  1/6/32  CDB port 2.
- index_a, index_b  in  6  operand tags to query.
- ready_a, ready_b  out  1  queried entry holds a result.
- value_a, value_b  out  32  result of queried entry.
- commit_valid  out  1  one entry retired (registered pulse).
- commit_dest  out  5  destination of retired entry.
- commit_data  out  32  value of retired entry.
- commit_rob  out  6  tag of retired entry.
- count  out  5  occupied entries, 0..16.

## Operation
- Storage per entry: busy, done, dest[4:0], data[31:0]. head and tail are 4-bit pointers that wrap 15->0. count is 5-bit.
- Allocation: on an edge with alloc_valid && alloc_ready, the tail entry is written with busy=1, done=0, dest=alloc_dest, and tail increments.
  - alloc_valid with alloc_ready=0 is ignored; dispatch must hold the request.
  - alloc_ready and alloc_rob are combinational from registered count and tail only. A commit in the same cycle does not enable allocation when full.
- CDB capture: for each port, if valid, rob<16, the entry is busy and done=0, then set done=1 and data=cdb_data.
  - Tags >=16, non-busy entries and already-done entries are ignored.
  - If both ports target the same entry in the same cycle, port 1 wins.
- Lookup (combinational):
  - index<16 && busy && done: ready=1, value=data.
  - Same-cycle CDB bypass: if a CDB port is valid with rob==index and the entry is busy, then ready=1 and value=CDB data. Port 1 has priority.
  - Otherwise ready=0, value=0. index>=16 always gives ready=0.
- Commit: at each edge, if the head entry is busy and done (registered state), retire it:
  - commit_valid=1; commit_dest, commit_data and commit_rob take the entry fields.
  - The entry's busy is cleared and head increments.
  - Otherwise commit_valid=0; the other commit outputs hold their previous values.
  - Maximum one retirement per cycle.
- count_next = count + alloc_fire - commit_fire. Simultaneous allocate and commit leaves count unchanged.
- Flush: clears all busy/done, head=tail=0, count=0, commit_valid=0. Allocation, CDB and commit in the flush cycle are discarded.
- Reset (async):
  - All state is as after flush.
  - commit_dest=0, commit_data=0, commit_rob=INVALID.
  - Resulting outputs: alloc_ready=1, alloc_rob=0, count=0, ready_a/b=0, value_a/b=0 (no bypass while reset asserted).
  - Reset deassertion mid-operation needs no special handling; everything is cleared.

## Timing
- Allocation to tag visible: alloc_rob is valid in the request cycle; the entry is busy after that edge.
- CDB result at edge E: lookup is ready in the same cycle via bypass and from storage after E. The earliest commit decision is at edge E+1; commit_valid is high in the cycle following E+1.
- An allocated entry can retire no earlier than 2 edges after allocation.
- Back-to-back retirement: one per cycle while consecutive head entries are done.
- Out-of-order completion: a done entry behind a not-done head waits. There is no retirement skipping.

## Test plan
- Reset, then allocate 3 (dests 1,2,3). Expect alloc_rob 0,1,2 and count=3. CDB tag 1 = 0x55: no commit. CDB tag 0 = 0x11: commits tag0/0x11 then tag1/0x55 on consecutive cycles. Tag 2 remains.
- Fill 16 entries: alloc_ready=0, alloc_rob=16, and a 17th alloc_valid is ignored. Complete tag 0 and it commits; the next cycle alloc_rob=0, confirming the wraparound of tail.
- Both CDB ports target tag 4 (0xAAAA on port 1, 0xBBBB on port 2) in one cycle: stored and committed data is 0xAAAA. Port 2 with tag 16 changes nothing.
- Lookup index_a=5 while CDB port 2 broadcasts tag 5 = 0x1234: same-cycle ready_a=1, value_a=0x1234. index_b=16 gives ready_b=0, value_b=0.
- With 5 entries and tags 2,3 done: pulse flush. Next cycle count=0, alloc_rob=0, commit_valid=0, and no stale retirement occurs afterward.
- Assert reset asynchronously between edges with 8 entries busy: outputs immediately take their reset values. After release, allocation restarts at tag 0.
